// File: rtl/axi_lite_slave.sv
// axi_lite_slave: AXI4-Lite slave bridging to a GP register-port strobe/done handshake.
// Define AXIL_ZERO_STROBE_SKIP_EN to answer all-zero-strobe writes with OKAY without a GP write.
module axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8,
  parameter int GP_ADDR_WIDTH = 6
) (
  input  logic                            s_axi_aclk,
  input  logic                            s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                      s_axi_awprot,
  input  logic                            s_axi_awvalid,
  output logic                            s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                            s_axi_wvalid,
  output logic                            s_axi_wready,
  output logic [1:0]                      s_axi_bresp,
  output logic                            s_axi_bvalid,
  input  logic                            s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                      s_axi_arprot,
  input  logic                            s_axi_arvalid,
  output logic                            s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                      s_axi_rresp,
  output logic                            s_axi_rvalid,
  input  logic                            s_axi_rready,
  output logic                            write,
  output logic [GP_ADDR_WIDTH-1:0]        write_addrs,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   write_data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0] write_strobe,
  input  logic                            write_done,
  input  logic                            write_error,
  output logic                            read,
  output logic [GP_ADDR_WIDTH-1:0]        read_addrs,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   read_data,
  input  logic                            read_done,
  input  logic                            read_error
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int GW = GP_ADDR_WIDTH;
  localparam int SW = DW / 8;
  typedef enum logic [1:0] {W_IDLE, W_GP, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_GP, R_RESP} r_state_e;
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [GW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [AW+GW-1:0] aw_word, ar_word;
  // Zero-extend before the shift so narrow or wide GP address widths both resize cleanly.
  assign aw_word = {{GW{1'b0}}, s_axi_awaddr} >> 2;
  assign ar_word = {{GW{1'b0}}, s_axi_araddr} >> 2;
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          aw_held_d = 1'b1;
          waddr_d   = aw_word[GW-1:0];
        end
        if (s_axi_wvalid && wready_q) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_wdata;
          wstrb_d  = s_axi_wstrb;
        end
        if (aw_held_d && w_held_d) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = 2'b00;
`ifdef AXIL_ZERO_STROBE_SKIP_EN
          w_state_d = (wstrb_d == '0) ? W_RESP : W_GP;
`else
          w_state_d = W_GP;
`endif
        end
      end
      W_GP: begin
        if (write_done) begin
          bresp_d   = write_error ? 2'b10 : 2'b00;
          w_state_d = W_RESP;
        end
      end
      W_RESP: w_state_d = s_axi_bready ? W_IDLE : W_RESP;
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          raddr_d   = ar_word[GW-1:0];
          r_state_d = R_GP;
        end
      end
      R_GP: begin
        if (read_done) begin
          rdata_d   = read_data;
          rresp_d   = read_error ? 2'b10 : 2'b00;
          r_state_d = R_RESP;
        end
      end
      R_RESP: r_state_d = s_axi_rready ? R_IDLE : R_RESP;
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wstrb_q   <= '0;
      waddr_q   <= '0;
      raddr_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wstrb_q   <= wstrb_d;
      waddr_q   <= waddr_d;
      raddr_q   <= raddr_d;
    end
  end
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = (r_state_q == R_RESP);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign write         = (w_state_q == W_GP);
  assign write_addrs   = waddr_q;
  assign write_data    = wdata_q;
  assign write_strobe  = wstrb_q;
  assign read          = (r_state_q == R_GP);
  assign read_addrs    = raddr_q;
endmodule

// File: tb/tb_axi_lite_slave.sv
// tb_axi_lite_slave: randomized AXI-Lite traffic against a queue-based transaction model;
// GP responders and B/R monitors pop expectations independently of the stimulus.
module tb_axi_lite_slave;
  localparam int NTX = 40;
  logic s_axi_aclk = 1'b0, s_axi_aresetn = 1'b1;
  logic [7:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [2:0] s_axi_awprot = '0, s_axi_arprot = '0;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic s_axi_bready = 1'b0, s_axi_rready = 1'b0;
  logic [31:0] s_axi_wdata = '0, read_data = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic write_done = 1'b0, write_error = 1'b0, read_done = 1'b0, read_error = 1'b0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, write_data;
  logic write, read;
  logic [5:0] write_addrs, read_addrs;
  logic [3:0] write_strobe;
  logic [90:0] outs;

  axi_lite_slave dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .write(write), .write_addrs(write_addrs), .write_data(write_data),
    .write_strobe(write_strobe), .write_done(write_done), .write_error(write_error),
    .read(read), .read_addrs(read_addrs), .read_data(read_data),
    .read_done(read_done), .read_error(read_error)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;
  assign outs = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                 s_axi_rvalid, s_axi_rresp, s_axi_rdata, write, write_addrs, write_data,
                 write_strobe, read, read_addrs};

  int n_cmp = 0, n_err = 0;
  bit hold = 1'b0;
  typedef struct {logic [5:0] a; logic [31:0] d; logic [3:0] s;} gpw_t;
  gpw_t gp_wq[$];
  logic [1:0] bq[$];
  logic [5:0] gp_rq[$];
  logic [33:0] rq[$];
  logic [31:0] wvals [4] = '{32'h12345678, 32'hDEADBEEF, 32'h0000E11E, 32'h22041195};
  logic [31:0] rvals [4] = '{32'hBABA1195, 32'hDEADBEEF, 32'h0000E11E, 32'h22041195};
  int plan_d [4] = '{0, 1, 2, 0};
  bit plan_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic void bad(string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no DUT response within bound", nm);
  endfunction

  task automatic aw_beat(input logic [7:0] a);
    int n = 0;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 200) begin @(negedge s_axi_aclk); n++; end
    if (!s_axi_awready) bad("aw_timeout");
    else begin @(posedge s_axi_aclk); #1; end
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    while (!s_axi_wready && n < 200) begin @(negedge s_axi_aclk); n++; end
    if (!s_axi_wready) bad("w_timeout");
    else begin @(posedge s_axi_aclk); #1; end
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
  endtask

  task automatic ar_beat(input logic [7:0] a);
    int n = 0;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    while (!s_axi_arready && n < 200) begin @(negedge s_axi_aclk); n++; end
    if (!s_axi_arready) bad("ar_timeout");
    else begin @(posedge s_axi_aclk); #1; end
    s_axi_arvalid = 1'b0; s_axi_araddr = '0;
  endtask

  task automatic gap_check();
    repeat (2) begin
      @(negedge s_axi_aclk);
      chk("early_write", {write, s_axi_bvalid}, 2'b00);
    end
  endtask

  task automatic run_writes();
    logic [7:0] a;
    logic [31:0] d;
    logic [3:0] s;
    int mode;
    for (int k = 0; k < NTX; k++) begin
      a = (k == 0) ? 8'h04 : 8'($urandom);
      d = (k < 4) ? wvals[k] : $urandom;
      s = (k < 4) ? 4'hF : 4'($urandom);
      mode = (k < 4) ? 0 : (k == 4) ? 1 : int'($urandom_range(0, 2));
      gp_wq.push_back('{a: 6'(a / 4), d: d, s: s});
      if (mode == 0) fork aw_beat(a); w_beat(d, s); join
      else if (mode == 1) begin aw_beat(a); gap_check(); w_beat(d, s); end
      else begin w_beat(d, s); gap_check(); aw_beat(a); end
    end
  endtask

  task automatic run_reads();
    logic [7:0] a;
    for (int k = 0; k < NTX; k++) begin
      a = (k == 0) ? 8'h04 : 8'($urandom);
      gp_rq.push_back(6'(a / 4));
      ar_beat(a);
      if (k >= 4) repeat ($urandom_range(0, 2)) @(negedge s_axi_aclk);
    end
  endtask

  initial begin : gp_write_side
    gpw_t e;
    int d, k;
    bit er;
    k = 0;
    forever begin
      @(negedge s_axi_aclk);
      if (write && !hold) begin
        e = '{a: '0, d: '0, s: '0};
        if (gp_wq.size() == 0) bad("unexpected_write");
        else begin
          e = gp_wq.pop_front();
          chk("write_addrs", write_addrs, e.a);
          chk("write_data", write_data, e.d);
          chk("write_strobe", write_strobe, e.s);
        end
        d = (k < 4) ? plan_d[k] : int'($urandom_range(0, 3));
        er = (k < 4) ? plan_e[k] : ($urandom_range(0, 3) == 0);
        k++;
        repeat (d) begin
          @(negedge s_axi_aclk);
          chk("write_held", {write, write_data}, {1'b1, e.d});
        end
        write_done = 1'b1; write_error = er;
        bq.push_back(er ? 2'b10 : 2'b00);
        @(negedge s_axi_aclk);
        write_done = 1'b0; write_error = 1'b0;
        chk("write_drop", write, 1'b0);
        chk("b_latency", s_axi_bvalid, 1'b1);
      end
    end
  end

  initial begin : gp_read_side
    logic [5:0] e;
    logic [31:0] v;
    int d, k;
    bit er;
    k = 0;
    forever begin
      @(negedge s_axi_aclk);
      if (read && !hold) begin
        e = '0;
        if (gp_rq.size() == 0) bad("unexpected_read");
        else begin
          e = gp_rq.pop_front();
          chk("read_addrs", read_addrs, e);
        end
        d = (k < 4) ? plan_d[k] : int'($urandom_range(0, 3));
        er = (k < 4) ? plan_e[k] : ($urandom_range(0, 3) == 0);
        v = (k < 4) ? rvals[k] : $urandom;
        k++;
        repeat (d) begin
          @(negedge s_axi_aclk);
          chk("read_held", {read, read_addrs}, {1'b1, e});
        end
        read_done = 1'b1; read_error = er; read_data = v;
        rq.push_back({er ? 2'b10 : 2'b00, v});
        @(negedge s_axi_aclk);
        read_done = 1'b0; read_error = 1'b0; read_data = '0;
        chk("read_drop", read, 1'b0);
        chk("r_latency", s_axi_rvalid, 1'b1);
      end
    end
  end

  initial begin : b_monitor
    forever begin
      @(negedge s_axi_aclk);
      s_axi_bready = hold || ($urandom_range(0, 2) != 0);
      if (s_axi_bvalid) begin
        chk("no_ready_in_b", {s_axi_awready, s_axi_wready}, 2'b00);
        if (bq.size() == 0) bad("unexpected_b");
        else begin
          chk("bresp", s_axi_bresp, bq[0]);
          if (s_axi_bready) void'(bq.pop_front());
        end
      end
    end
  end

  initial begin : r_monitor
    forever begin
      @(negedge s_axi_aclk);
      s_axi_rready = hold || ($urandom_range(0, 2) != 0);
      if (s_axi_rvalid) begin
        chk("no_ready_in_r", s_axi_arready, 1'b0);
        if (rq.size() == 0) bad("unexpected_r");
        else begin
          chk("rresp", s_axi_rresp, rq[0][33:32]);
          chk("rdata", s_axi_rdata, rq[0][31:0]);
          if (s_axi_rready) void'(rq.pop_front());
        end
      end
    end
  end

  initial begin : main
    int n;
    #2 s_axi_aresetn = 1'b0;
    #1 chk("reset_outputs", outs, '0);
    repeat (2) @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    #1 chk("ready_before_edge", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
    @(negedge s_axi_aclk);
    chk("ready_after_edge", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    fork run_writes(); run_reads(); join
    n = 0;
    while ((gp_wq.size() != 0 || bq.size() != 0 || gp_rq.size() != 0 || rq.size() != 0 ||
            write || read || s_axi_bvalid || s_axi_rvalid) && n < 500) begin
      @(negedge s_axi_aclk); n++;
    end
    if (n == 500) bad("drain");
    hold = 1'b1;
    @(negedge s_axi_aclk);
    fork aw_beat(8'h10); w_beat(32'hA5A5A5A5, 4'h3); join
    n = 0;
    while (!write && n < 50) begin @(negedge s_axi_aclk); n++; end
    if (!write) bad("reset_write");
    else chk("reset_write_addrs", write_addrs, 6'h04);
    @(posedge s_axi_aclk);
    #2 s_axi_aresetn = 1'b0;
    #1 chk("reset_mid_outputs", outs, '0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    repeat (2) @(negedge s_axi_aclk);
    chk("post_reset_idle", {write, s_axi_bvalid, s_axi_awready, s_axi_wready, s_axi_arready},
        5'b00111);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_lite_slave.md
Name: axi_lite_slave

Overview:
AXI4-Lite slave bridge that converts AXI4-Lite write and read transactions into a simple general-purpose (GP) register-port handshake: write/read strobes with a held address, plus done/error inputs.
- Sits between an AXI interconnect and user register logic.
- Write and read paths are fully independent and may run concurrently.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI and GP data width (multiple of 8).
C_S_AXI_ADDR_WIDTH, 8, AXI byte-address width.
GP_ADDR_WIDTH, 6, GP word-address width; GP address = AXI address >> 2, truncated or zero-extended to GP_ADDR_WIDTH.

Ports:
s_axi_aclk  in  1  clock, all logic on rising edge.
s_axi_aresetn  in  1  asynchronous active-low reset.
s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
s_axi_awprot  in  3  ignored.
s_axi_awvalid / s_axi_awready  in/out  1  AW handshake.
s_axi_wdata  in  C_S_AXI_DATA_WIDTH  write data.
s_axi_wstrb  in  C_S_AXI_DATA_WIDTH/8  byte strobes.
s_axi_wvalid / s_axi_wready  in/out  1  W handshake.
s_axi_bresp  out  2  write response.
s_axi_bvalid / s_axi_bready  out/in  1  B handshake.
s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
s_axi_arprot  in  3  ignored.
s_axi_arvalid / s_axi_arready  in/out  1  AR handshake.
s_axi_rdata  out  C_S_AXI_DATA_WIDTH  read data.
s_axi_rresp  out  2  read response.
s_axi_rvalid / s_axi_rready  out/in  1  R handshake.
write  out  1  GP write request, level.
write_addrs  out  GP_ADDR_WIDTH  latched write word address.
write_data  out  C_S_AXI_DATA_WIDTH  latched write data.
write_strobe  out  C_S_AXI_DATA_WIDTH/8  latched strobes.
write_done  in  1  GP accepts write this cycle.
write_error  in  1  GP write failed; sampled with write_done.
read  out  1  GP read request, level.
read_addrs  out  GP_ADDR_WIDTH  latched read word address.
read_data  in  C_S_AXI_DATA_WIDTH  GP read data; sampled with read_done.
read_done  in  1  GP read data valid this cycle.
read_error  in  1  GP read failed; sampled with read_done.

Behaviour:
Reset (async, aresetn=0):
- All outputs, latches and states clear to 0, both FSMs go to IDLE.
- Readies are registered: low during reset, high from the first rising edge after release.
- Reset mid-transaction aborts it with no response.

Write FSM, states W_IDLE, W_GP, W_RESP:
- W_IDLE: awready=1 until the AW beat is latched; wready=1 until the W beat is latched. The two beats may arrive in either order or together; each is latched on its valid&ready edge (addr>>2, data, strb).
- When both beats are held, go to W_GP on the next edge.
- W_GP: write=1 with write_addrs, write_data and write_strobe stable. On an edge where write_done=1, register bresp = write_error ? 2'b10 (SLVERR) : 2'b00 (OKAY), deassert write, go to W_RESP.
- If write_done is already high, write is high for exactly 1 cycle.
- W_RESP: bvalid=1 and bresp stable until bready=1 at an edge, then go to W_IDLE with readies re-asserted.
- AW and W readies stay 0 outside W_IDLE.
- Minimum latency: AW/W edge -> write 1 cycle -> bvalid next cycle.

Read FSM, states R_IDLE, R_GP, R_RESP:
- R_IDLE: arready=1. The araddr>>2 latch happens on arvalid&arready; go to R_GP.
- R_GP: read=1 with read_addrs stable. On an edge where read_done=1, capture read_data into rdata and set rresp = read_error ? 2'b10 : 2'b00; go to R_RESP.
- R_RESP: rvalid=1 and rdata/rresp held until rready=1, then go to R_IDLE.
- GP-side and AXI-side inputs may change after capture without affecting outputs.
- Simultaneous read and write are independent; GP may see read and write high together.

Optional Feature:
Macro AXIL_ZERO_STROBE_SKIP_EN.
- Defined: a write with wstrb==0 bypasses W_GP (write never pulses) and goes directly to W_RESP with OKAY.
- Undefined: every write is forwarded to GP regardless of strobes.

Test Plan:
- GP always done, bready=rready=1; AW+W+AR together with awaddr=0x4, wdata=0x12345678, read_data=0xBABA1195 -> write and read each 1 cycle with addrs=1; bvalid/rvalid next cycle, rdata=0xBABA1195, OKAY.
- write_done/read_done asserted 1 and then 2 cycles late, wdata/read_data=0xDEADBEEF then 0xE11E -> write/read held high until done; response follows next cycle.
- bready/rready held low 1 and 2 cycles, data 0x22041195 -> bvalid/rvalid and rdata stay stable until ready; no new readies meanwhile.
- Inputs wdata/araddr/read_data changed to 0 after capture -> write_data, read_addrs and rdata keep the latched values.
- write_error=1 and read_error=1 at done -> bresp=rresp=2'b10.
- AW presented 2 cycles before W, and aresetn pulsed in W_GP -> write only after both beats; reset returns all outputs to 0.
